// File: rtl/tile_blwl_cfg_sequencer.sv
// Tile configuration writer: streams DATA_W-bit slices onto the bl/wl memory
// interface, giving each slice bl setup, a WL_PULSE-cycle wl strobe and bl hold.
module tile_blwl_cfg_sequencer #(
  parameter int NUM_BITS = 160,
  parameter int DATA_W   = 8,
  parameter int WL_PULSE = 2,
  localparam int NUM_WORDS = NUM_BITS / DATA_W,
  localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                prog_clk,
  input  logic                prog_reset_n,
  input  logic                start,
  input  logic                abort,
  input  logic [DATA_W-1:0]   cfg_data,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  output logic [0:NUM_BITS-1] bl,
  output logic [0:NUM_BITS-1] wl,
  output logic                busy,
  output logic                done,
  output logic [IDX_W-1:0]    word_idx
);

  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_DONE
  } state_t;

  state_t              state_reg, state_next;
  logic [IDX_W-1:0]    word_idx_reg, word_idx_next;
  logic [DATA_W-1:0]   slice_reg, slice_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [0:NUM_BITS-1] bl_reg, bl_next;
  logic [0:NUM_BITS-1] wl_reg, wl_next;
  logic                busy_reg, busy_next;
  logic                done_reg, done_next;
  logic                bl_en, wl_en;

  always_ff @(posedge prog_clk) begin
    if (!prog_reset_n) begin
      state_reg    <= ST_IDLE;
      word_idx_reg <= '0;
      slice_reg    <= '0;
      cnt_reg      <= '0;
      bl_reg       <= '0;
      wl_reg       <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      word_idx_reg <= word_idx_next;
      slice_reg    <= slice_next;
      cnt_reg      <= cnt_next;
      bl_reg       <= bl_next;
      wl_reg       <= wl_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    word_idx_next = word_idx_reg;
    slice_next    = slice_reg;
    cnt_next      = cnt_reg;
    cfg_ready     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next    = ST_LOAD;
          word_idx_next = '0;
        end
      end
      ST_LOAD: begin
        cfg_ready = ~abort;
        if (cfg_valid) begin
          slice_next = cfg_data;
          state_next = ST_SETUP;
        end
      end
      ST_SETUP: begin
        cnt_next   = '0;
        state_next = ST_PULSE;
      end
      ST_PULSE: begin
        if (cnt_reg == CNT_W'(WL_PULSE - 1)) state_next = ST_HOLD;
        else                                 cnt_next   = cnt_reg + 1'b1;
      end
      ST_HOLD: begin
        if (word_idx_reg == IDX_W'(NUM_WORDS - 1)) begin
          state_next = ST_DONE;
        end else begin
          word_idx_next = word_idx_reg + 1'b1;
          state_next    = ST_LOAD;
        end
      end
      ST_DONE: begin
        state_next    = ST_IDLE;
        word_idx_next = '0;
      end
      default: begin
        state_next    = ST_IDLE;
        word_idx_next = '0;
      end
    endcase
    // Abort overrides everything, including a start or handshake this cycle.
    if (abort) begin
      state_next    = ST_IDLE;
      word_idx_next = '0;
    end
  end

  // bl/wl are registered from the state being entered so they line up with it.
  assign bl_en     = (state_next == ST_SETUP) || (state_next == ST_PULSE) ||
                     (state_next == ST_HOLD);
  assign wl_en     = (state_next == ST_PULSE);
  assign busy_next = (state_next != ST_IDLE);
  assign done_next = (state_next == ST_DONE);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BITS; gi++) begin : g_cell
      localparam int WORD = gi / DATA_W;
      localparam int BIT  = gi % DATA_W;
      logic sel;
      assign sel         = (word_idx_next == IDX_W'(WORD));
      assign bl_next[gi] = bl_en & sel & slice_next[BIT];
      assign wl_next[gi] = wl_en & sel;
    end
  endgenerate

  assign bl       = bl_reg;
  assign wl       = wl_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign word_idx = word_idx_reg;

endmodule

// File: tb/tb_tile_blwl_cfg_sequencer.sv
// Directed bench for tile_blwl_cfg_sequencer: timing of full writes, stalls,
// abort, mid-write reset and ignored start, plus per-cycle bl/wl invariants.
module tb_tile_blwl_cfg_sequencer;

  localparam int NUM_BITS  = 160;
  localparam int DATA_W    = 8;
  localparam int WL_PULSE  = 2;
  localparam int NUM_WORDS = NUM_BITS / DATA_W;
  localparam int IDX_W     = $clog2(NUM_WORDS);

  logic                prog_clk;
  logic                prog_reset_n;
  logic                start;
  logic                abort;
  logic [DATA_W-1:0]   cfg_data;
  logic                cfg_valid;
  logic                cfg_ready;
  logic [0:NUM_BITS-1] bl;
  logic [0:NUM_BITS-1] wl;
  logic                busy;
  logic                done;
  logic [IDX_W-1:0]    word_idx;

  tile_blwl_cfg_sequencer #(
    .NUM_BITS(NUM_BITS), .DATA_W(DATA_W), .WL_PULSE(WL_PULSE)
  ) dut (
    .prog_clk(prog_clk), .prog_reset_n(prog_reset_n), .start(start),
    .abort(abort), .cfg_data(cfg_data), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .bl(bl), .wl(wl), .busy(busy), .done(done),
    .word_idx(word_idx)
  );

  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [DATA_W-1:0]   stream [NUM_WORDS];
  logic [0:NUM_BITS-1] image;
  logic [0:NUM_BITS-1] prev_wl, prev_bl;
  int cyc, feed_idx, stall_slice, stall_left, pulse_run;
  int done_cnt, done_cyc, busy_fall;
  int hs_cyc [32];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [DATA_W-1:0] slice_of(input logic [0:NUM_BITS-1] v, input int k);
    logic [DATA_W-1:0] r;
    for (int j = 0; j < DATA_W; j++) r[j] = v[k*DATA_W+j];
    return r;
  endfunction

  // One clock: monitor at negedge, then advance past the next rising edge.
  task automatic tick();
    logic hs;
    int nsl;
    @(negedge prog_clk);
    check("wl_rise_with_bl_change", 32'(|(wl & ~prev_wl) && (bl != prev_bl)), 0);
    check("bl_change_while_wl_high", 32'(|wl && (bl != prev_bl)), 0);
    nsl = 0;
    for (int k = 0; k < NUM_WORDS; k++) if (|slice_of(wl, k)) nsl++;
    check("one_wl_slice", 32'(nsl <= 1), 1);
    pulse_run = (|wl) ? pulse_run + 1 : 0;
    check("wl_pulse_len", 32'(pulse_run <= WL_PULSE), 1);
    for (int i = 0; i < NUM_BITS; i++) if (prev_wl[i] && !wl[i]) image[i] = prev_bl[i];
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (!cfg_valid && cfg_ready && stall_left > 0) begin
      check("stall_wl_low", 32'(|wl), 0);
      stall_left--;
    end
    hs = cfg_valid && cfg_ready;
    if (hs && feed_idx < 32) hs_cyc[feed_idx] = cyc;
    prev_wl = wl;
    prev_bl = bl;
    @(posedge prog_clk);
    #1;
    cyc++;
    if (hs) feed_idx++;
    cfg_data  = stream[(feed_idx < NUM_WORDS) ? feed_idx : NUM_WORDS-1];
    cfg_valid = !(feed_idx == stall_slice && stall_left > 0);
  endtask

  // Drives a write from a start at cycle 0; stops once busy drops or at the bound.
  task automatic run(input int stall_s, input int stall_n, input int abort_c,
                     input int rst_c, input int sp_a, input int sp_b, input bit chk_t);
    cyc = 0; feed_idx = 0; done_cnt = 0; done_cyc = -1; busy_fall = -1;
    stall_slice = stall_s; stall_left = stall_n;
    image = '0;
    for (int i = 0; i < 32; i++) hs_cyc[i] = -1;
    cfg_data = stream[0];
    cfg_valid = !(stall_s == 0 && stall_n > 0);
    while (cyc < 200) begin
      start        = (cyc == 0 || cyc == sp_a || cyc == sp_b);
      abort        = (cyc == abort_c);
      prog_reset_n = (cyc != rst_c);
      tick();
      if (chk_t && cyc == 2) check("s0_bl_setup", 32'(slice_of(bl, 0)), 32'(stream[0]));
      if (chk_t && cyc == 2) check("s0_wl_setup", 32'(slice_of(wl, 0)), 0);
      if (chk_t && (cyc == 3 || cyc == 4)) check("s0_wl_pulse", 32'(slice_of(wl, 0)), 32'hFF);
      if (chk_t && cyc == 4) check("s0_bl_pulse", 32'(slice_of(bl, 0)), 32'(stream[0]));
      if (chk_t && cyc == 5) check("s0_wl_hold", 32'(slice_of(wl, 0)), 0);
      if (chk_t && cyc == 5) check("s0_bl_hold", 32'(slice_of(bl, 0)), 32'(stream[0]));
      if (chk_t && cyc == 6) check("s0_bl_load", 32'(|bl), 0);
      if (cyc == abort_c) check("abort_in_pulse", 32'(slice_of(wl, 10)), 32'hFF);
      if (cyc == abort_c + 1) begin
        check("abort_wl", 32'(|wl), 0);
        check("abort_bl", 32'(|bl), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_word_idx", 32'(word_idx), 0);
      end
      if (cyc == rst_c) check("rst_in_pulse", 32'(slice_of(wl, 5)), 32'hFF);
      if (cyc == rst_c + 1) begin
        check("rst_wl", 32'(|wl), 0);
        check("rst_bl", 32'(|bl), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_word_idx", 32'(word_idx), 0);
        check("rst_cfg_ready", 32'(cfg_ready), 0);
      end
      if (!busy && busy_fall < 0 && cyc > 1) busy_fall = cyc;
      if (cyc > 1 && !busy) break;
    end
    start = 1'b0; abort = 1'b0; prog_reset_n = 1'b1;
  endtask

  task automatic check_image();
    for (int k = 0; k < NUM_WORDS; k++)
      check($sformatf("image_s%0d", k), 32'(slice_of(image, k)), 32'(stream[k]));
  endtask

  initial begin
    prog_reset_n = 1'b0; start = 1'b0; abort = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
    prev_wl = '0; prev_bl = '0; pulse_run = 0; cyc = 0; feed_idx = 0;
    stall_slice = -1; stall_left = 0; done_cnt = 0; done_cyc = -1; image = '0;
    for (int k = 0; k < NUM_WORDS; k++) stream[k] = 8'hA0 + 8'(k);
    repeat (3) tick();
    check("reset_bl", 32'(|bl), 0);
    check("reset_wl", 32'(|wl), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_word_idx", 32'(word_idx), 0);
    check("reset_cfg_ready", 32'(cfg_ready), 0);
    prog_reset_n = 1'b1;
    tick();

    // Full write, valid held high.
    run(-1, 0, -1, -1, -1, -1, 1'b1);
    check("full_hs0", hs_cyc[0], 1);
    check("full_hs19", hs_cyc[19], 96);
    check("full_done_cyc", done_cyc, 101);
    check("full_done_cnt", done_cnt, 1);
    check("full_busy_fall", busy_fall, 102);
    check_image();
    repeat (2) tick();

    // Backpressure: 7 stalled LOAD cycles before slice 3.
    for (int k = 0; k < NUM_WORDS; k++) stream[k] = 8'h5C ^ 8'(k * 37);
    run(3, 7, -1, -1, -1, -1, 1'b0);
    check("stall_hs2", hs_cyc[2], 11);
    check("stall_hs3", hs_cyc[3], 23);
    check("stall_hs4", hs_cyc[4], 28);
    check("stall_done_cyc", done_cyc, 108);
    check("stall_done_cnt", done_cnt, 1);
    check_image();
    repeat (2) tick();

    // Abort during PULSE of slice 10, then a fresh full write.
    run(-1, 0, 53, -1, -1, -1, 1'b0);
    check("abort_no_done", done_cnt, 0);
    repeat (3) tick();
    check("abort_idle_busy", 32'(busy), 0);
    for (int k = 0; k < NUM_WORDS; k++) stream[k] = 8'h3E + 8'(k * 11);
    run(-1, 0, -1, -1, -1, -1, 1'b0);
    check("post_abort_done_cyc", done_cyc, 101);
    check_image();
    repeat (2) tick();

    // Reset during PULSE of slice 5.
    run(-1, 0, -1, 28, -1, -1, 1'b0);
    check("rst_no_done", done_cnt, 0);
    repeat (2) tick();

    // Start pulses while busy are ignored.
    for (int k = 0; k < NUM_WORDS; k++) stream[k] = ~(8'h11 * 8'(k % 15)) ^ 8'(k);
    run(-1, 0, -1, -1, 30, 60, 1'b0);
    check("start_busy_done_cyc", done_cyc, 101);
    check("start_busy_done_cnt", done_cnt, 1);
    check("start_busy_fall", busy_fall, 102);
    check_image();
    repeat (2) tick();

    // start and abort together in IDLE.
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", 32'(busy), 0);
    check("start_abort_ready", 32'(cfg_ready), 0);
    tick();
    check("start_abort_busy2", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
